onehot_seq_encoder: RTL and testbench
=====================================

# onehot_seq_encoder

Receive-side companion to the 2-to-4 one-hot state decoder. The block takes the 4-bit one-hot state bus that drives the charge-state logic and encodes it back to a 2-bit state code. It also checks that the bus stays legal and steps in the expected order 0→1→2→3→0, and measures how long each state is held. Its outputs feed the LED/debug path and any supervisor logic that must detect a stuck or corrupted state sequencer.

## Interface
- `W_DWELL`, default 32: width of the dwell counter.
- `STALL_LIMIT`, default 100000000: dwell count at or above which `stall` asserts (2 s at 50 MHz).
- `clk`, in, 1: system clock; all logic on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `onehot_in`, in, 4: one-hot state; bit n set means state n.
- `clr_err`, in, 1: synchronous clear of the sticky error flags.
- `code`, out, 2: encoded index of the last accepted legal state.
- `valid`, out, 1: the most recently evaluated input sample was legal (exactly one bit set).
- `step`, out, 1: one-cycle pulse on an in-order transition.
- `dwell`, out, `W_DWELL`: cycles spent in the current state; saturates.
- `err_illegal`, out, 1: sticky; an illegal sample was seen (zero bits or more than one bit set).
- `err_seq`, out, 1: sticky; a legal but out-of-order transition was seen.
- `stall`, out, 1: `dwell >= STALL_LIMIT`.

## Operation
**Input stage**
- `onehot_in` is registered into `in_q` on every edge.
- All evaluation below uses `in_q`.

**State machine** (two states)
- `NOREF`: no legal state seen since reset.
- `TRACK`: a reference `code` is held.

**`NOREF`, legal `in_q` with index e**
- `code`←e, `dwell`←0, `valid`←1, `step`←0.
- Go to `TRACK`. No sequence check is made on this first load.

**`TRACK`, legal `in_q` with index e**
- e == `code`: `dwell`←`dwell`+1, saturating at 2^`W_DWELL`−1. `step`←0.
- e == (`code`+1) mod 4: `code`←e, `dwell`←0, `step`←1. Wrap 3→0 counts as in order.
- Any other e: `code`←e, `dwell`←0, `step`←0, `err_seq`←1.

**Illegal `in_q`, either FSM state**
- `valid`←0, `err_illegal`←1, `step`←0.
- `code`, `dwell` and the FSM state are held.
- A glitch does not break the sequence reference: the next legal sample is checked against the held `code`.

**Sticky flags**
- `clr_err`=1 clears `err_illegal` and `err_seq` at the edge.
- If an error event occurs at the same edge, set wins and the flag stays 1.

**`stall`**
- Combinational from the `dwell` register: `stall` = (`dwell` >= `STALL_LIMIT`).
- Clears when `dwell` reloads to 0.

**Width rules**
- `code` arithmetic is mod 4.
- `dwell` never wraps.

## Timing
**Reset**
- Asserting `rst` immediately forces: `in_q`=0, FSM=`NOREF`, `code`=0, `valid`=0, `step`=0, `dwell`=0, `err_illegal`=0, `err_seq`=0, `stall`=0.
- Reset may be asserted mid-operation at any time.
- After release, the first legal sample reloads the reference with no `err_seq`.
- An all-zero `in_q` in `NOREF` does set `err_illegal`.

**Latency**
- A change on `onehot_in` that is set up before edge k is captured into `in_q` at edge k.
- `code`, `valid`, `step`, `dwell` and the error flags reflect it after edge k+1: 2-cycle latency.
- `stall` follows `dwell` in the same cycle.

**`step`**
- High for exactly one cycle per in-order transition.
- Back-to-back transitions on consecutive samples give consecutive pulses.

**Hold counting**
- An input held for N sampled cycles ends with `dwell`=N−1.

## Test plan
- **Reset values:** assert `rst` with `onehot_in`=0001 → all outputs 0. Release → two edges later `code`=0, `valid`=1, `step`=0, `err_seq`=0.
- **In-order cycle:** drive 0001, 0010, 0100, 1000, 0001, each for 3 cycles → `code` = 0,1,2,3,0. Four `step` pulses, one per transition including the 3→0 wrap. `dwell` peaks at 2. No errors.
- **Skip:** in `TRACK` with `code`=0, drive 0100 → `code`=2, `step`=0, `err_seq`=1. Assert `clr_err` at the same edge as a second skip → `err_seq` stays 1. A later `clr_err` alone → 0.
- **Illegal glitch:** with `code`=1, drive 0011 for one cycle, then 0100 → during the glitch `valid`=0, `err_illegal`=1, `code`=1 and `dwell` held. Afterwards `code`=2, `step`=1, `err_seq`=0.
- **Stall and saturation:** with `STALL_LIMIT`=5, `W_DWELL`=3, hold 0010 → `stall` rises when `dwell`=5. `dwell` saturates at 7. Changing to 0100 → `dwell`=0, `stall`=0.
- **Async reset mid-run:** pulse `rst` between clock edges while `dwell`=4 and `err_seq`=1 → all outputs go to 0 before the next edge. The next sample 1000 loads `code`=3 with no `err_seq`.

Source files
------------

// File: rtl/onehot_seq_encoder_if.sv
// Handshake bundle between a one-hot state sequencer and its encoder/monitor.
// master: drives onehot_in/clr_err, reads status. slave: the encoder side.
interface onehot_seq_encoder_if #(
  parameter int W_DWELL = 32
);
  logic [3:0]         onehot_in;
  logic               clr_err;
  logic [1:0]         code;
  logic               valid;
  logic               step;
  logic [W_DWELL-1:0] dwell;
  logic               err_illegal;
  logic               err_seq;
  logic               stall;

  modport master (
    output onehot_in,
    output clr_err,
    input  code,
    input  valid,
    input  step,
    input  dwell,
    input  err_illegal,
    input  err_seq,
    input  stall
  );

  modport slave (
    input  onehot_in,
    input  clr_err,
    output code,
    output valid,
    output step,
    output dwell,
    output err_illegal,
    output err_seq,
    output stall
  );
endinterface

// File: rtl/onehot_seq_encoder.sv
// Encodes a 4-bit one-hot state bus to a 2-bit code, checks legality and
// 0->1->2->3->0 ordering, and measures dwell time per state.
// Ports: clk, rst (async, active-high), bus (slave modport):
//   onehot_in, clr_err in; code, valid, step, dwell, err_illegal,
//   err_seq, stall out.
module onehot_seq_encoder #(
  parameter int          W_DWELL     = 32,
  parameter int unsigned STALL_LIMIT = 100000000
) (
  input  logic                 clk,
  input  logic                 rst,
  onehot_seq_encoder_if.slave  bus
);

  typedef enum logic {
    NOREF = 1'b0,
    TRACK = 1'b1
  } state_t;

  localparam logic [W_DWELL-1:0] DWELL_MAX = {W_DWELL{1'b1}};
  localparam logic [63:0]        LIMIT     = 64'(STALL_LIMIT);

  state_t             state;
  logic [3:0]         in_q;
  logic [1:0]         code_q;
  logic               valid_q;
  logic               step_q;
  logic [W_DWELL-1:0] dwell_q;
  logic               err_ill_q;
  logic               err_seq_q;

  logic               legal;
  logic [1:0]         idx;
  logic [1:0]         next_code;

  always_comb begin
    legal = 1'b1;
    idx   = 2'd0;
    case (in_q)
      4'b0001: idx = 2'd0;
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: legal = 1'b0;
    endcase
  end

  // 2-bit add wraps 3 -> 0, so the wrap is an in-order step.
  assign next_code = code_q + 2'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_q      <= 4'b0000;
      state     <= NOREF;
      code_q    <= 2'd0;
      valid_q   <= 1'b0;
      step_q    <= 1'b0;
      dwell_q   <= '0;
      err_ill_q <= 1'b0;
      err_seq_q <= 1'b0;
    end else begin
      in_q   <= bus.onehot_in;
      step_q <= 1'b0;

      // Clear first so an error event below at the same edge wins.
      if (bus.clr_err) begin
        err_ill_q <= 1'b0;
        err_seq_q <= 1'b0;
      end

      if (!legal) begin
        // Glitch: hold code/dwell/state so the next legal
        // sample is still checked against the old reference.
        valid_q   <= 1'b0;
        err_ill_q <= 1'b1;
      end else begin
        valid_q <= 1'b1;
        unique case (state)
          NOREF: begin
            code_q  <= idx;
            dwell_q <= '0;
            state   <= TRACK;
          end
          TRACK: begin
            if (idx == code_q) begin
              if (dwell_q != DWELL_MAX)
                dwell_q <= dwell_q + W_DWELL'(1);
            end else begin
              code_q  <= idx;
              dwell_q <= '0;
              if (idx == next_code)
                step_q <= 1'b1;
              else
                err_seq_q <= 1'b1;
            end
          end
          default: state <= NOREF;
        endcase
      end
    end
  end

  assign bus.code        = code_q;
  assign bus.valid       = valid_q;
  assign bus.step        = step_q;
  assign bus.dwell       = dwell_q;
  assign bus.err_illegal = err_ill_q;
  assign bus.err_seq     = err_seq_q;
  assign bus.stall       = (64'(dwell_q) >= LIMIT);

endmodule

// File: tb/tb_onehot_seq_encoder.sv
// Directed bench for onehot_seq_encoder (W_DWELL=3, STALL_LIMIT=5).
// Checks reset, ordering, skips, glitches, stall/saturation, async reset.
module tb_onehot_seq_encoder;

  logic clk;
  logic rst;
  int   total;
  int   passed;
  int   steps;
  int   peak;

  logic [3:0] seq [4];
  int         exp_code [4];

  onehot_seq_encoder_if #(.W_DWELL(3)) bus ();

  onehot_seq_encoder #(
    .W_DWELL(3),
    .STALL_LIMIT(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_code"}, 32'(bus.code), 0);
    chk({tag, "_valid"}, 32'(bus.valid), 0);
    chk({tag, "_step"}, 32'(bus.step), 0);
    chk({tag, "_dwell"}, 32'(bus.dwell), 0);
    chk({tag, "_eill"}, 32'(bus.err_illegal), 0);
    chk({tag, "_eseq"}, 32'(bus.err_seq), 0);
    chk({tag, "_stall"}, 32'(bus.stall), 0);
  endtask

  initial begin
    total  = 0;
    passed = 0;
    seq      = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_code = '{1, 2, 3, 0};

    // Reset values
    rst = 1'b1;
    bus.onehot_in = 4'b0001;
    bus.clr_err   = 1'b0;
    #3;
    chk_zero("rst");
    tick;
    rst = 1'b0;

    // First evaluated sample is the reset in_q=0: illegal in NOREF
    tick;
    chk("noref_valid", 32'(bus.valid), 0);
    chk("noref_eill", 32'(bus.err_illegal), 1);
    tick;
    chk("load_code", 32'(bus.code), 0);
    chk("load_valid", 32'(bus.valid), 1);
    chk("load_step", 32'(bus.step), 0);
    chk("load_eseq", 32'(bus.err_seq), 0);
    chk("load_dwell", 32'(bus.dwell), 0);
    bus.clr_err = 1'b1;
    tick;
    bus.clr_err = 1'b0;
    chk("clr_eill", 32'(bus.err_illegal), 0);
    chk("hold_dwell", 32'(bus.dwell), 1);

    // In-order cycle with 3->0 wrap
    steps = 0;
    peak  = 0;
    for (int g = 0; g < 4; g++) begin
      bus.onehot_in = seq[g];
      for (int t = 0; t < 3; t++) begin
        tick;
        steps += int'(bus.step);
        if (int'(bus.dwell) > peak) peak = int'(bus.dwell);
        if (t == 1) begin
          chk("cyc_code", 32'(bus.code), 32'(exp_code[g]));
          chk("cyc_step", 32'(bus.step), 1);
        end
      end
    end
    chk("cyc_steps", 32'(steps), 4);
    chk("cyc_peak", 32'(peak), 2);
    chk("cyc_eseq", 32'(bus.err_seq), 0);
    chk("cyc_eill", 32'(bus.err_illegal), 0);

    // Skip 0 -> 2
    bus.onehot_in = 4'b0100;
    tick;
    tick;
    chk("skip_code", 32'(bus.code), 2);
    chk("skip_step", 32'(bus.step), 0);
    chk("skip_eseq", 32'(bus.err_seq), 1);
    // Second skip 2 -> 0 with clr_err at the same edge: set wins
    bus.onehot_in = 4'b0001;
    tick;
    bus.clr_err = 1'b1;
    tick;
    bus.clr_err = 1'b0;
    chk("setwin_eseq", 32'(bus.err_seq), 1);
    chk("setwin_code", 32'(bus.code), 0);
    tick;
    chk("sticky_eseq", 32'(bus.err_seq), 1);
    bus.clr_err = 1'b1;
    tick;
    bus.clr_err = 1'b0;
    chk("clr_eseq", 32'(bus.err_seq), 0);

    // Illegal glitch 0011 with code=1
    bus.onehot_in = 4'b0010;
    tick;
    tick;
    chk("gl_pre_code", 32'(bus.code), 1);
    chk("gl_pre_step", 32'(bus.step), 1);
    tick;
    bus.onehot_in = 4'b0011;
    tick;
    bus.onehot_in = 4'b0100;
    tick;
    chk("gl_valid", 32'(bus.valid), 0);
    chk("gl_eill", 32'(bus.err_illegal), 1);
    chk("gl_code", 32'(bus.code), 1);
    chk("gl_dwell", 32'(bus.dwell), 2);
    tick;
    chk("gl_post_code", 32'(bus.code), 2);
    chk("gl_post_step", 32'(bus.step), 1);
    chk("gl_post_eseq", 32'(bus.err_seq), 0);
    chk("gl_post_valid", 32'(bus.valid), 1);
    chk("gl_post_eill", 32'(bus.err_illegal), 1);

    // Back-to-back steps 2->3->0->1 on consecutive samples
    bus.onehot_in = 4'b1000;
    tick;
    bus.onehot_in = 4'b0001;
    tick;
    chk("b2b_code3", 32'(bus.code), 3);
    chk("b2b_step3", 32'(bus.step), 1);
    bus.onehot_in = 4'b0010;
    tick;
    chk("b2b_code0", 32'(bus.code), 0);
    chk("b2b_step0", 32'(bus.step), 1);
    tick;
    chk("b2b_code1", 32'(bus.code), 1);
    chk("b2b_step1", 32'(bus.step), 1);
    chk("b2b_dwell", 32'(bus.dwell), 0);

    // Stall at dwell=5, saturation at 7
    repeat (4) tick;
    chk("st_dwell4", 32'(bus.dwell), 4);
    chk("st_stall4", 32'(bus.stall), 0);
    tick;
    chk("st_dwell5", 32'(bus.dwell), 5);
    chk("st_stall5", 32'(bus.stall), 1);
    repeat (3) tick;
    chk("st_sat", 32'(bus.dwell), 7);
    chk("st_stall7", 32'(bus.stall), 1);
    bus.onehot_in = 4'b0100;
    tick;
    tick;
    chk("st_rl_code", 32'(bus.code), 2);
    chk("st_rl_dwell", 32'(bus.dwell), 0);
    chk("st_rl_stall", 32'(bus.stall), 0);

    // Async reset mid-run with dwell=4, err_seq=1
    bus.onehot_in = 4'b0001;
    tick;
    tick;
    repeat (4) tick;
    chk("ar_dwell", 32'(bus.dwell), 4);
    chk("ar_eseq", 32'(bus.err_seq), 1);
    #2;
    rst = 1'b1;
    #1;
    chk_zero("arst");
    rst = 1'b0;
    bus.onehot_in = 4'b1000;
    tick;
    tick;
    chk("ar_code", 32'(bus.code), 3);
    chk("ar_valid", 32'(bus.valid), 1);
    chk("ar_post_eseq", 32'(bus.err_seq), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
